windowed_register_file: RTL and testbench
=========================================

// Module: windowed_register_file
// PURPOSE
//  Windowed SPARC integer register file; consumes Register_Dest_Sel from the RF destination-select mux.
//  Provides one write port, two combinational read ports, the current window pointer (CWP) and the window invalid mask (WIM).
//  SAVE and RESTORE rotate the window. Window overflow and underflow are detected here and flagged to the control unit.
// PARAMETERS
//  NWINDOWS  4   number of register windows (2..32); physical regs = 8 + 16*NWINDOWS
//  WIDTH     32  data width
// PORTS
//  Clk                input   1          rising-edge clock
//  Reset_n            input   1          asynchronous, active-low reset
//  Register_Dest_Sel  input   5          logical write register r0..r31
//  RF_Write_En        input   1          write strobe
//  RF_Write_Data      input   WIDTH      write data
//  RS1_Sel, RS2_Sel   input   5 each     logical read registers
//  RS1_Data, RS2_Data output  WIDTH each combinational read data
//  Save, Restore      input   1 each     window rotate request, one cycle
//  CWP_Load           input   1          load CWP from CWP_In (WRPSR)
//  CWP_In             input   clog2(N)   new CWP value
//  WIM_Load           input   1          load WIM from WIM_In (WRWIM)
//  WIM_In             input   NWINDOWS   new WIM value
//  CWP                output  clog2(N)   current window pointer
//  WIM                output  NWINDOWS   window invalid mask
//  Window_Overflow    output  1          one-cycle pulse: SAVE into an invalid window
//  Window_Underflow   output  1          one-cycle pulse: RESTORE into an invalid window
// BEHAVIOUR
//  Reset (async, Reset_n=0): all physical regs 0, CWP=0, WIM=0, both trap pulses 0. Mid-operation reset aborts any pending write.
//  Logical-to-physical mapping for window w:
//    r0-r7    -> phys 0-7 (globals)
//    r8-r15   -> 8+16w+(r-8)
//    r16-r23  -> 8+16w+(r-8)
//    r24-r31  -> 8+16*((w+1)%N)+(r-24)
//  r0 always reads 0. Writes to r0 are discarded.
//  Reads: combinational, always mapped through the current registered CWP.
//  SAVE: target T=(CWP-1) mod N; 0 wraps to N-1.
//    WIM[T]=1: Window_Overflow=1 next cycle, CWP unchanged, write suppressed.
//    Otherwise CWP<=T, and a same-cycle write lands in window T (callee rd).
//  RESTORE: T=(CWP+1) mod N; N-1 wraps to 0.
//    WIM[T]=1: Window_Underflow=1 next cycle, CWP unchanged, write suppressed.
//    Otherwise CWP<=T, and the write lands in window T.
//  Priority:
//    CWP_Load beats Save/Restore; the write uses CWP_In's window, no trap.
//    Save and Restore together: neither executes, no trap; the write uses the current window.
//  WIM_Load takes effect next cycle. The trap check in the same cycle uses the old WIM.
//  Trap outputs are registered and high for exactly one cycle per offending request.
//  Write latency: 1 cycle (data visible on the read ports in the cycle after RF_Write_En).
// CONFIGURATION
//  RF_WRITE_BYPASS_EN defined:
//    A read whose mapped physical index equals this cycle's effective write index (write enabled, not r0) returns RF_Write_Data.
//    Compare only against the current-CWP mapping. No bypass across a rotating window.
//  RF_WRITE_BYPASS_EN undefined: reads return stored contents only. Write visible next cycle.
// STRUCTURE
//  Package sparc_rf_pkg:
//    constants NUM_GLOBALS=8, WINDOW_STRIDE=16
//    logical register range constants
//    function phys_index(logical, window, nwindows)
//  Sub-module rf_window_map: logical reg + window -> physical index.
//    Instantiated three times: write port, RS1, RS2.
//  Top: register array, CWP/WIM registers, trap logic, optional bypass.
// TESTING
//  1. Reset, write r0=0xDEAD -> RS1_Sel=0 reads 0. Write r5=0x1234 -> r5 reads 0x1234 next cycle from any CWP.
//  2. N=4, CWP=0, WIM=0:
//     write r8=0xAAAA; Save -> CWP=3.
//     Read r24 -> 0xAAAA. Restore -> CWP=0, r8 still 0xAAAA.
//  3. WIM=4'b0100, CWP=3: Save -> Window_Overflow for 1 cycle, CWP stays 3, same-cycle write not stored.
//  4. WIM=4'b0001, CWP=3: Restore -> Window_Underflow pulse, CWP=3. CWP=0 Save wraps to 3 with WIM=0.
//  5. Save+Restore together -> CWP unchanged, no trap. CWP_Load(2)+Save -> CWP=2.
//  6. RF_WRITE_BYPASS_EN: write r16=0x55 and read r16 same cycle -> 0x55. Without macro -> old value, then 0x55.

Source files
------------

// File: rtl/sparc_rf_pkg.sv
// sparc_rf_pkg
//   Shared constants and the logical-to-physical register mapping for the
//   windowed SPARC integer register file.
//   Contents:
//     NUM_GLOBALS, WINDOW_STRIDE  - physical layout constants
//     REG_ZERO/REG_OUT_FIRST/REG_IN_FIRST - logical register range bounds
//     rot_kind_e                  - window rotation request classification
//     phys_index()                - logical reg + window -> physical index
package sparc_rf_pkg;

    localparam int unsigned NUM_GLOBALS   = 8;
    localparam int unsigned WINDOW_STRIDE = 16;

    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam logic [4:0] REG_OUT_FIRST = 5'd8;
    localparam logic [4:0] REG_IN_FIRST  = 5'd24;

    typedef enum logic [1:0] {
        ROT_NONE,
        ROT_SAVE,
        ROT_RESTORE,
        ROT_LOAD
    } rot_kind_e;

    // Outs and locals (r8-r23) sit in the window's own 16-entry slice; ins
    // (r24-r31) alias the outs of the next-higher window, modulo nwindows.
    function automatic int unsigned phys_index(input logic [4:0]  logical,
                                               input int unsigned window,
                                               input int unsigned nwindows);
        if (logical < REG_OUT_FIRST)
            return 32'(logical);
        else if (logical < REG_IN_FIRST)
            return NUM_GLOBALS + WINDOW_STRIDE * window
                   + 32'(logical - REG_OUT_FIRST);
        else
            return NUM_GLOBALS + WINDOW_STRIDE * ((window + 1) % nwindows)
                   + 32'(logical - REG_IN_FIRST);
    endfunction

endpackage

// File: rtl/rf_window_map.sv
// rf_window_map
//   Purely combinational translation of a logical register number within a
//   given window to a physical register-array index.
//   Ports:
//     logical_reg  in   5    logical register r0..r31
//     window       in   CW   window number (0..NWINDOWS-1)
//     phys_idx     out  PW   physical index into the register array
module rf_window_map
    import sparc_rf_pkg::*;
#(
    parameter int unsigned NWINDOWS = 4,
    localparam int unsigned CW      = $clog2(NWINDOWS),
    localparam int unsigned PW      = $clog2(NUM_GLOBALS + WINDOW_STRIDE * NWINDOWS)
) (
    input  logic [4:0]    logical_reg,
    input  logic [CW-1:0] window,
    output logic [PW-1:0] phys_idx
);

    assign phys_idx = PW'(phys_index(logical_reg, 32'(window), NWINDOWS));

endmodule

// File: rtl/windowed_register_file.sv
// windowed_register_file
//   Windowed SPARC integer register file: one write port, two combinational
//   read ports, current window pointer (CWP) and window invalid mask (WIM).
//   SAVE/RESTORE rotate the window; rotating into a window marked invalid in
//   WIM raises a one-cycle Window_Overflow / Window_Underflow pulse instead.
//   Ports:
//     Clk, Reset_n                 clock, async active-low reset
//     Register_Dest_Sel, RF_Write_En, RF_Write_Data   write port
//     RS1_Sel/RS1_Data, RS2_Sel/RS2_Data              combinational reads
//     Save, Restore                window rotate requests
//     CWP_Load/CWP_In, WIM_Load/WIM_In                direct CWP/WIM writes
//     CWP, WIM                     current window state
//     Window_Overflow, Window_Underflow               registered trap pulses
//   Configuration:
//     RF_WRITE_BYPASS_EN - when defined, a read of the register being written
//     this cycle returns RF_Write_Data (only when the window is not rotating).
module windowed_register_file
    import sparc_rf_pkg::*;
#(
    parameter int unsigned NWINDOWS = 4,
    parameter int unsigned WIDTH    = 32,
    localparam int unsigned CW      = $clog2(NWINDOWS),
    localparam int unsigned NPHYS   = NUM_GLOBALS + WINDOW_STRIDE * NWINDOWS,
    localparam int unsigned PW      = $clog2(NPHYS)
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [4:0]          Register_Dest_Sel,
    input  logic                RF_Write_En,
    input  logic [WIDTH-1:0]    RF_Write_Data,
    input  logic [4:0]          RS1_Sel,
    input  logic [4:0]          RS2_Sel,
    output logic [WIDTH-1:0]    RS1_Data,
    output logic [WIDTH-1:0]    RS2_Data,
    input  logic                Save,
    input  logic                Restore,
    input  logic                CWP_Load,
    input  logic [CW-1:0]       CWP_In,
    input  logic                WIM_Load,
    input  logic [NWINDOWS-1:0] WIM_In,
    output logic [CW-1:0]       CWP,
    output logic [NWINDOWS-1:0] WIM,
    output logic                Window_Overflow,
    output logic                Window_Underflow
);

    logic [WIDTH-1:0] regs [NPHYS];

    rot_kind_e     rot;
    logic [CW-1:0] save_target;
    logic [CW-1:0] restore_target;
    logic [CW-1:0] load_val;
    logic [CW-1:0] next_cwp;
    logic          save_trap;
    logic          restore_trap;
    logic          wr_en_eff;

    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rs1_idx;
    logic [PW-1:0] rs2_idx;

    // Classify the rotation request; CWP_Load wins, Save+Restore cancel.
    always_comb begin
        rot = ROT_NONE;
        if (CWP_Load)
            rot = ROT_LOAD;
        else if (Save && !Restore)
            rot = ROT_SAVE;
        else if (Restore && !Save)
            rot = ROT_RESTORE;
    end

    always_comb begin
        save_target    = (CWP == '0) ? CW'(NWINDOWS - 1) : CWP - CW'(1);
        restore_target = (CWP == CW'(NWINDOWS - 1)) ? '0 : CWP + CW'(1);
        // Keeps a non-power-of-two window count from selecting a window
        // that does not exist.
        load_val       = CW'(32'(CWP_In) % NWINDOWS);
    end

    // The write always targets the window that will be current next cycle,
    // so a SAVE/RESTORE instruction's rd lands in the new window.
    always_comb begin
        next_cwp     = CWP;
        save_trap    = 1'b0;
        restore_trap = 1'b0;
        unique case (rot)
            ROT_LOAD: next_cwp = load_val;
            ROT_SAVE: begin
                if (WIM[save_target])
                    save_trap = 1'b1;
                else
                    next_cwp = save_target;
            end
            ROT_RESTORE: begin
                if (WIM[restore_target])
                    restore_trap = 1'b1;
                else
                    next_cwp = restore_target;
            end
            default: ;
        endcase
        wr_en_eff = RF_Write_En && (Register_Dest_Sel != REG_ZERO)
                    && !save_trap && !restore_trap;
    end

    rf_window_map #(.NWINDOWS(NWINDOWS)) u_map_wr (
        .logical_reg (Register_Dest_Sel),
        .window      (next_cwp),
        .phys_idx    (wr_idx)
    );

    rf_window_map #(.NWINDOWS(NWINDOWS)) u_map_rs1 (
        .logical_reg (RS1_Sel),
        .window      (CWP),
        .phys_idx    (rs1_idx)
    );

    rf_window_map #(.NWINDOWS(NWINDOWS)) u_map_rs2 (
        .logical_reg (RS2_Sel),
        .window      (CWP),
        .phys_idx    (rs2_idx)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            CWP              <= '0;
            WIM              <= '0;
            Window_Overflow  <= 1'b0;
            Window_Underflow <= 1'b0;
        end else begin
            CWP              <= next_cwp;
            if (WIM_Load)
                WIM <= WIM_In;
            Window_Overflow  <= save_trap;
            Window_Underflow <= restore_trap;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < NPHYS; i++)
                regs[i] <= '0;
        end else if (wr_en_eff) begin
            regs[wr_idx] <= RF_Write_Data;
        end
    end

`ifdef RF_WRITE_BYPASS_EN
    // Bypass only when the write index was computed in the same window the
    // reads are mapped through.
    logic bypass_ok;
    assign bypass_ok = wr_en_eff && (next_cwp == CWP);
`endif

    always_comb begin
        RS1_Data = regs[rs1_idx];
        RS2_Data = regs[rs2_idx];
`ifdef RF_WRITE_BYPASS_EN
        if (bypass_ok && (rs1_idx == wr_idx))
            RS1_Data = RF_Write_Data;
        if (bypass_ok && (rs2_idx == wr_idx))
            RS2_Data = RF_Write_Data;
`endif
        if (RS1_Sel == REG_ZERO)
            RS1_Data = '0;
        if (RS2_Sel == REG_ZERO)
            RS2_Data = '0;
    end

endmodule

// File: tb/tb_windowed_register_file.sv
// tb_windowed_register_file
//   Directed test of windowed_register_file (NWINDOWS=4, WIDTH=32).
module tb_windowed_register_file;

    logic        Clk;
    logic        Reset_n;
    logic [4:0]  Register_Dest_Sel;
    logic        RF_Write_En;
    logic [31:0] RF_Write_Data;
    logic [4:0]  RS1_Sel;
    logic [4:0]  RS2_Sel;
    logic [31:0] RS1_Data;
    logic [31:0] RS2_Data;
    logic        Save;
    logic        Restore;
    logic        CWP_Load;
    logic [1:0]  CWP_In;
    logic        WIM_Load;
    logic [3:0]  WIM_In;
    logic [1:0]  CWP;
    logic [3:0]  WIM;
    logic        Window_Overflow;
    logic        Window_Underflow;

    int checks   = 0;
    int failures = 0;

    windowed_register_file #(.NWINDOWS(4), .WIDTH(32)) dut (
        .Clk               (Clk),
        .Reset_n           (Reset_n),
        .Register_Dest_Sel (Register_Dest_Sel),
        .RF_Write_En       (RF_Write_En),
        .RF_Write_Data     (RF_Write_Data),
        .RS1_Sel           (RS1_Sel),
        .RS2_Sel           (RS2_Sel),
        .RS1_Data          (RS1_Data),
        .RS2_Data          (RS2_Data),
        .Save              (Save),
        .Restore           (Restore),
        .CWP_Load          (CWP_Load),
        .CWP_In            (CWP_In),
        .WIM_Load          (WIM_Load),
        .WIM_In            (WIM_In),
        .CWP               (CWP),
        .WIM               (WIM),
        .Window_Overflow   (Window_Overflow),
        .Window_Underflow  (Window_Underflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        RF_Write_En       = 1'b0;
        Register_Dest_Sel = 5'd0;
        RF_Write_Data     = '0;
        Save              = 1'b0;
        Restore           = 1'b0;
        CWP_Load          = 1'b0;
        CWP_In            = '0;
        WIM_Load          = 1'b0;
        WIM_In            = '0;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        RF_Write_En       = 1'b1;
        Register_Dest_Sel = r;
        RF_Write_Data     = d;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        idle();
        RS1_Sel = 5'd5;
        RS2_Sel = 5'd0;
        Reset_n = 1'b0;
        #2;
        check("rst_cwp", 32'(CWP), 32'd0);
        check("rst_wim", 32'(WIM), 32'd0);
        check("rst_ovf", 32'(Window_Overflow), 32'd0);
        check("rst_unf", 32'(Window_Underflow), 32'd0);
        check("rst_r5", RS1_Data, 32'd0);
        step();
        Reset_n = 1'b1;
        step();

        // 1. r0 discards writes; globals visible from any window
        wr(5'd0, 32'hDEAD);
        step();
        idle();
        RS1_Sel = 5'd0;
        #1;
        check("r0_zero", RS1_Data, 32'd0);
        wr(5'd5, 32'h1234);
        step();
        idle();
        RS1_Sel = 5'd5;
        #1;
        check("r5_w0", RS1_Data, 32'h1234);
        CWP_Load = 1'b1;
        CWP_In   = 2'd2;
        step();
        idle();
        RS2_Sel = 5'd5;
        #1;
        check("load_cwp2", 32'(CWP), 32'd2);
        check("r5_w2", RS2_Data, 32'h1234);
        CWP_Load = 1'b1;
        CWP_In   = 2'd0;
        step();
        idle();

        // 2. SAVE from 0 wraps to 3; caller outs become callee ins
        wr(5'd8, 32'hAAAA);
        step();
        idle();
        Save = 1'b1;
        wr(5'd9, 32'h3333);
        step();
        idle();
        RS1_Sel = 5'd24;
        RS2_Sel = 5'd9;
        #1;
        check("save_cwp3", 32'(CWP), 32'd3);
        check("save_ovf0", 32'(Window_Overflow), 32'd0);
        check("r24_w3", RS1_Data, 32'hAAAA);
        check("r9_w3_callee", RS2_Data, 32'h3333);
        Restore = 1'b1;
        step();
        idle();
        RS1_Sel = 5'd8;
        RS2_Sel = 5'd9;
        #1;
        check("restore_cwp0", 32'(CWP), 32'd0);
        check("r8_w0", RS1_Data, 32'hAAAA);
        check("r9_w0_untouched", RS2_Data, 32'd0);

        // 3. overflow
        CWP_Load = 1'b1;
        CWP_In   = 2'd3;
        WIM_Load = 1'b1;
        WIM_In   = 4'b0100;
        step();
        idle();
        check("wim_4", 32'(WIM), 32'h4);
        check("cwp_3", 32'(CWP), 32'd3);
        Save = 1'b1;
        wr(5'd10, 32'hBEEF);
        step();
        idle();
        RS1_Sel = 5'd10;
        #1;
        check("ovf_pulse", 32'(Window_Overflow), 32'd1);
        check("ovf_cwp", 32'(CWP), 32'd3);
        check("ovf_wr_suppressed", RS1_Data, 32'd0);
        step();
        check("ovf_one_cycle", 32'(Window_Overflow), 32'd0);

        // 4. underflow, and same-cycle WIM_Load uses old WIM
        WIM_Load = 1'b1;
        WIM_In   = 4'b0001;
        step();
        idle();
        Restore = 1'b1;
        wr(5'd11, 32'h0077);
        step();
        idle();
        check("unf_pulse", 32'(Window_Underflow), 32'd1);
        check("unf_cwp", 32'(CWP), 32'd3);
        Restore  = 1'b1;
        WIM_Load = 1'b1;
        WIM_In   = 4'b0000;
        step();
        idle();
        RS1_Sel = 5'd11;
        #1;
        check("unf_old_wim", 32'(Window_Underflow), 32'd1);
        check("unf_cwp2", 32'(CWP), 32'd3);
        check("wim_cleared", 32'(WIM), 32'd0);
        check("unf_wr_suppressed", RS1_Data, 32'd0);
        step();
        check("unf_one_cycle", 32'(Window_Underflow), 32'd0);
        CWP_Load = 1'b1;
        CWP_In   = 2'd0;
        step();
        idle();
        Save = 1'b1;
        step();
        idle();
        check("wrap_cwp3", 32'(CWP), 32'd3);
        check("wrap_no_ovf", 32'(Window_Overflow), 32'd0);

        // 5. priority
        Save    = 1'b1;
        Restore = 1'b1;
        wr(5'd12, 32'h1212);
        step();
        idle();
        RS1_Sel = 5'd12;
        #1;
        check("both_cwp", 32'(CWP), 32'd3);
        check("both_no_ovf", 32'(Window_Overflow), 32'd0);
        check("both_no_unf", 32'(Window_Underflow), 32'd0);
        check("both_wr_cur", RS1_Data, 32'h1212);
        WIM_Load = 1'b1;
        WIM_In   = 4'b0100;
        step();
        idle();
        CWP_Load = 1'b1;
        CWP_In   = 2'd2;
        Save     = 1'b1;
        wr(5'd13, 32'h1313);
        step();
        idle();
        RS1_Sel = 5'd13;
        #1;
        check("load_beats_save", 32'(CWP), 32'd2);
        check("load_no_ovf", 32'(Window_Overflow), 32'd0);
        check("load_wr_win", RS1_Data, 32'h1313);
        WIM_Load = 1'b1;
        WIM_In   = 4'b0000;
        step();
        idle();

        // 6. same-cycle read of the register being written
        wr(5'd16, 32'h55);
        RS1_Sel = 5'd16;
        #1;
`ifdef RF_WRITE_BYPASS_EN
        check("bypass_same", RS1_Data, 32'h55);
`else
        check("nobypass_same", RS1_Data, 32'd0);
`endif
        step();
        idle();
        #1;
        check("r16_next", RS1_Data, 32'h55);

        // mid-operation reset aborts the pending write
        wr(5'd6, 32'h66);
        #2;
        Reset_n = 1'b0;
        RS1_Sel = 5'd5;
        #1;
        check("mid_rst_cwp", 32'(CWP), 32'd0);
        check("mid_rst_r5", RS1_Data, 32'd0);
        step();
        idle();
        Reset_n = 1'b1;
        RS1_Sel = 5'd6;
        step();
        check("mid_rst_r6", RS1_Data, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
